conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_lane_sum.sv | 24 ++
 rtl/conv_mac_engine.sv | 112 +++++++++++
 tb/tb_conv_mac_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the convolution MAC engine.
// Optional build macro: MAC_SATURATE_EN (clamping accumulator instead of wrapping).
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int KLEN   = 9;
  localparam int ACC_W  = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational dot product of one beat: sum of LANES full-width products,
// zero-extended to ACC_W.
module mac_lane_sum #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int LANES  = mac_pkg::LANES,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic [LANES*DATA_W-1:0] pixel,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic [ACC_W-1:0]        lane_sum
);

  logic [2*DATA_W-1:0] prod [LANES];

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i]  = {{DATA_W{1'b0}}, pixel[i*DATA_W +: DATA_W]} *
                 {{DATA_W{1'b0}}, weight[i*DATA_W +: DATA_W]};
      lane_sum = lane_sum + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Kernel MAC engine: accumulates KLEN beats of LANES pixel*weight products.
// Define MAC_SATURATE_EN to clamp the accumulator at 2^ACC_W-1 instead of wrapping.
module conv_mac_engine #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int LANES  = mac_pkg::LANES,
  parameter int KLEN   = mac_pkg::KLEN,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] pixel,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        result
);

  import mac_pkg::*;

  localparam int CNT_W = $clog2(KLEN + 1);

  if (ACC_W < 2*DATA_W + $clog2(LANES)) begin : g_bad_acc_w
    $error("conv_mac_engine: ACC_W too narrow for DATA_W/LANES");
  end
  if (KLEN < 1) begin : g_bad_klen
    $error("conv_mac_engine: KLEN must be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] acc_q, acc_d, acc_add;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] lane_sum;
  logic             accept;

  mac_lane_sum #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .ACC_W  (ACC_W)
  ) u_lane_sum (
    .pixel    (pixel),
    .weight   (weight),
    .lane_sum (lane_sum)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? acc_q : '0;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // One extra carry bit exposes the overflow for the saturating build.
  assign acc_sum = {1'b0, acc_q} + {1'b0, lane_sum};

`ifdef MAC_SATURATE_EN
  assign acc_add = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_add = acc_sum[ACC_W-1:0];
`endif

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          acc_d   = lane_sum;
          cnt_d   = CNT_W'(1);
          state_d = (KLEN == 1) ? DONE : ACC;
        end
        ACC: if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(KLEN)) state_d = DONE;
        end
        DONE: if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: behavioural kernel-sum model, directed
// scenarios and randomized traffic. Honours MAC_SATURATE_EN like the design.
module tb_conv_mac_engine;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int KL = 9;
  localparam int AW = 20;
  localparam longint AMAX = (longint'(1) << AW) - 1;

  logic           clk, rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [LN*DW-1:0] pixel, weight;
  logic [AW-1:0]  result;

  logic           o_clr, o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [LN*DW-1:0] o_pixel, o_weight;
  logic [AW-1:0]  o_result;

  int tests = 0;
  int fails = 0;

  conv_mac_engine #(.DATA_W(DW), .LANES(LN), .KLEN(KL), .ACC_W(AW)) u_main (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .pixel(pixel), .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  conv_mac_engine #(.DATA_W(DW), .LANES(LN), .KLEN(1), .ACC_W(AW)) u_one (
    .clk(clk), .rst(rst), .clr(o_clr), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .pixel(o_pixel), .weight(o_weight), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .result(o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint beat_sum(input logic [LN*DW-1:0] p, input logic [LN*DW-1:0] w);
    longint s = 0;
    for (int i = 0; i < LN; i++) s += longint'(p[i*DW +: DW]) * longint'(w[i*DW +: DW]);
    return s;
  endfunction

  function automatic longint accumulate(input longint a, input longint b);
`ifdef MAC_SATURATE_EN
    return (a + b > AMAX) ? AMAX : a + b;
`else
    return (a + b) % (AMAX + 1);
`endif
  endfunction

  function automatic logic [LN*DW-1:0] rep(input logic [DW-1:0] v);
    return {LN{v}};
  endfunction

  // Behavioural model: running kernel sum, beats seen so far, result waiting for pickup.
  longint m_sum = 0;
  int     m_beats = 0;
  bit     m_hold = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_sum = 0; m_beats = 0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 1'b0; m_sum = 0; end
    end else if (in_valid) begin
      m_sum = accumulate((m_beats == 0) ? 0 : m_sum, beat_sum(pixel, weight));
      m_beats++;
      if (m_beats == KL) begin m_hold = 1'b1; m_beats = 0; end
    end
  end

  always @(negedge clk) begin
    check("out_valid", longint'(out_valid), longint'(m_hold));
    check("in_ready", longint'(in_ready), longint'(!m_hold));
    check("result", longint'(result), m_hold ? m_sum : 0);
  end

  task automatic beat(input logic [DW-1:0] p, input logic [DW-1:0] w);
    in_valid = 1'b1; pixel = rep(p); weight = rep(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic kernel(input logic [DW-1:0] p, input logic [DW-1:0] w, input int gap);
    for (int i = 0; i < KL; i++) begin
      beat(p, w);
      if (i < KL - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic release_result();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pixel = '0; weight = '0;
    o_clr = 1'b0; o_in_valid = 1'b0; o_out_ready = 1'b0; o_pixel = '0; o_weight = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_result", longint'(result), 0);

    // Basic kernel: 9 beats of 1x2 -> 72, valid on the cycle after the last beat.
    kernel(8'd1, 8'd2, 0);
    @(negedge clk);
    check("basic_latency", longint'(out_valid), 1);
    check("basic_result", longint'(result), 72);
    check("basic_model", m_sum, 72);
    check("basic_in_ready", longint'(in_ready), 0);
    release_result();

    // Overflow: all operands 255.
    kernel(8'd255, 8'd255, 0);
    @(negedge clk);
`ifdef MAC_SATURATE_EN
    check("overflow_result", longint'(result), 1048575);
    check("overflow_model", m_sum, 1048575);
`else
    check("overflow_result", longint'(result), 243748);
    check("overflow_model", m_sum, 243748);
`endif
    release_result();

    // Stalls on both sides.
    kernel(8'd1, 8'd2, 3);
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_valid", longint'(out_valid), 1);
      check("stall_hold_result", longint'(result), 72);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_still_done", longint'(out_valid), 1);
    @(negedge clk);
    check("stall_idle_valid", longint'(out_valid), 0);
    check("stall_idle_ready", longint'(in_ready), 1);
    out_ready = 1'b0;

    // Clear mid-kernel, with a beat offered in the clear cycle that must be dropped.
    for (int i = 0; i < 4; i++) beat(8'd3, 8'd3);
    clr = 1'b1; in_valid = 1'b1; pixel = rep(8'd9); weight = rep(8'd9);
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", longint'(out_valid), 0);
    check("clr_in_ready", longint'(in_ready), 1);
    kernel(8'd1, 8'd1, 0);
    @(negedge clk);
    check("clr_next_result", longint'(result), 36);
    release_result();

    // Asynchronous reset while holding a result.
    kernel(8'd1, 8'd2, 0);
    @(negedge clk);
    check("areset_pre_valid", longint'(out_valid), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("areset_out_valid", longint'(out_valid), 0);
    check("areset_result", longint'(result), 0);
    check("areset_in_ready", longint'(in_ready), 1);
    #1 rst = 1'b0;
    kernel(8'd2, 8'd3, 0);
    @(negedge clk);
    check("areset_next_result", longint'(result), 216);
    release_result();

    // Single-beat kernel instance.
    o_pixel  = {8'd4, 8'd3, 8'd2, 8'd1};
    o_weight = {8'd8, 8'd7, 8'd6, 8'd5};
    @(negedge clk);
    check("one_idle_valid", longint'(o_out_valid), 0);
    check("one_idle_ready", longint'(o_in_ready), 1);
    @(posedge clk); #1 o_in_valid = 1'b1;
    @(posedge clk); #1 o_in_valid = 1'b0;
    @(negedge clk);
    check("one_valid", longint'(o_out_valid), 1);
    check("one_result", longint'(o_result), 70);
    check("one_in_ready", longint'(o_in_ready), 0);
    @(posedge clk); #1 o_out_ready = 1'b1;
    @(posedge clk); #1 o_out_ready = 1'b0;
    @(negedge clk);
    check("one_back_idle", longint'(o_out_valid), 0);
    check("one_result_zero", longint'(o_result), 0);

    // Randomized traffic against the model.
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) begin
        pixel = rep(8'hff); weight = rep(8'hff);
      end else begin
        pixel = $urandom; weight = $urandom;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
